// File: rtl/systolic_ctrl_if.sv
// Control/handshake bundle between a systolic array controller and its user/PE array.
interface systolic_ctrl_if #(
  parameter int unsigned NW = 2,
  parameter int unsigned VW = 8
);
  logic          start;
  logic          abort;
  logic [VW-1:0] num_vec;
  logic          busy;
  logic          done;
  logic          wwrite;
  logic [NW-1:0] w_addr;
  logic          active;
  logic [VW-1:0] d_addr;
  logic          out_valid;
  logic [VW-1:0] out_idx;

  modport master (
    output start, abort, num_vec,
    input  busy, done, wwrite, w_addr, active, d_addr, out_valid, out_idx
  );

  modport slave (
    input  start, abort, num_vec,
    output busy, done, wwrite, w_addr, active, d_addr, out_valid, out_idx
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Job sequencer for an NxN systolic array: weight load, activation stream,
// pipeline flush and completion pulse. All outputs are registered.
module systolic_ctrl #(
  parameter int unsigned N  = 4,
  parameter int unsigned NW = 2,
  parameter int unsigned VW = 8
) (
  input logic            clk,
  input logic            rst_n,
  systolic_ctrl_if.slave bus
);

  localparam int unsigned LAT = 2 * N - 1;
  // One shared counter wide enough for weight rows, vector index and flush length.
  localparam int unsigned CW0 = (VW > 5) ? VW : 5;
  localparam int unsigned CW  = (NW > CW0) ? NW : CW0;

  typedef enum logic [2:0] {StIdle, StLoadw, StStream, StFlush, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CW-1:0]     r_cnt, w_cnt_d;
  logic [VW-1:0]     r_nv, w_nv_d;
  logic              r_busy, r_done, r_wwrite, r_active;
  logic [NW-1:0]     r_w_addr;
  logic [VW-1:0]     r_d_addr;
  // Result delay line: entry LAT-1 is what appears at the array bottom now.
  logic [LAT-1:0]          r_dly_v;
  logic [LAT-1:0][VW-1:0]  r_dly_i;
  logic              w_kill;

  assign w_kill = bus.abort && (r_state != StIdle);

  // Next-state and counter sequencing; abort overrides every active state.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_nv_d    = r_nv;
    unique case (r_state)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          w_state_d = StLoadw;
          w_cnt_d   = '0;
          w_nv_d    = bus.num_vec;
        end
      end
      StLoadw: begin
        if (r_cnt == CW'(N - 1)) begin
          w_cnt_d   = '0;
          w_state_d = (r_nv != '0) ? StStream : StDone;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StStream: begin
        // r_nv is non-zero here, so the compare never underflows.
        if (r_cnt == CW'(r_nv) - CW'(1)) begin
          w_cnt_d   = '0;
          w_state_d = StFlush;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StFlush: begin
        if (r_cnt == CW'(LAT - 1)) begin
          w_cnt_d   = '0;
          w_state_d = StDone;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
    if (w_kill) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end
  end

  // State, job length and registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_nv     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wwrite <= 1'b0;
      r_w_addr <= '0;
      r_active <= 1'b0;
      r_d_addr <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_nv     <= w_nv_d;
      r_busy   <= (w_state_d != StIdle);
      r_done   <= (w_state_d == StDone);
      r_wwrite <= (w_state_d == StLoadw);
      r_w_addr <= (w_state_d == StLoadw) ? w_cnt_d[NW-1:0] : '0;
      r_active <= (w_state_d == StStream);
      r_d_addr <= (w_state_d == StStream) ? w_cnt_d[VW-1:0] : '0;
    end
  end

  // Delay active/d_addr by LAT cycles; d_addr is 0 when idle so out_idx is 0 when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_v <= '0;
      r_dly_i <= '0;
    end else if (w_kill) begin
      r_dly_v <= '0;
      r_dly_i <= '0;
    end else begin
      r_dly_v <= {r_dly_v[LAT-2:0], r_active};
      r_dly_i <= {r_dly_i[LAT-2:0], r_d_addr};
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wwrite    = r_wwrite;
  assign bus.w_addr    = r_w_addr;
  assign bus.active    = r_active;
  assign bus.d_addr    = r_d_addr;
  assign bus.out_valid = r_dly_v[LAT-1];
  assign bus.out_idx   = r_dly_i[LAT-1];

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed + randomized bench for systolic_ctrl, checked against a per-cycle
// timeline model derived from job length, array size and abort point.
module tb_systolic_ctrl;
  localparam int N   = 4;
  localparam int NW  = 2;
  localparam int VW  = 8;
  localparam int LAT = 2 * N - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  systolic_ctrl_if #(.NW(NW), .VW(VW)) u_if ();

  systolic_ctrl #(.N(N), .NW(NW), .VW(VW)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int t, input bit eb, input bit ed,
                          input bit ew, input int ewa, input bit ea, input int eda,
                          input bit eov, input int eoi);
    chk({tag, ".busy"},      t, 32'(u_if.busy),      32'(eb));
    chk({tag, ".done"},      t, 32'(u_if.done),      32'(ed));
    chk({tag, ".wwrite"},    t, 32'(u_if.wwrite),    32'(ew));
    chk({tag, ".w_addr"},    t, 32'(u_if.w_addr),    32'(ewa));
    chk({tag, ".active"},    t, 32'(u_if.active),    32'(ea));
    chk({tag, ".d_addr"},    t, 32'(u_if.d_addr),    32'(eda));
    chk({tag, ".out_valid"}, t, 32'(u_if.out_valid), 32'(eov));
    chk({tag, ".out_idx"},   t, 32'(u_if.out_idx),   32'(eoi));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one job from IDLE; t counts cycles after the start-sampling edge.
  // abort_at>0 raises abort during that cycle; poke re-pulses start while busy.
  task automatic run_job(input int nv, input int abort_at, input bit poke, input string tag);
    int  tdone, tend, ewa, eda, eoi;
    bit  live, eb, ed, ew, ea, eov;
    tdone = (nv == 0) ? N + 1 : N + nv + LAT + 1;
    tend  = (abort_at > 0) ? abort_at + 3 : tdone + 2;
    u_if.num_vec = VW'(nv);
    u_if.start   = 1'b1;
    u_if.abort   = 1'b0;
    tick();
    u_if.start   = 1'b0;
    u_if.num_vec = VW'($urandom);
    for (int t = 1; t <= tend; t++) begin
      live = (abort_at == 0) || (t <= abort_at);
      eb   = live && (t <= tdone);
      ed   = live && (t == tdone);
      ew   = live && (t <= N);
      ewa  = ew ? t - 1 : 0;
      ea   = live && (t > N) && (t <= N + nv);
      eda  = ea ? t - N - 1 : 0;
      eov  = live && (t > N + LAT) && (t <= N + nv + LAT);
      eoi  = eov ? t - N - LAT - 1 : 0;
      chk_outs(tag, t, eb, ed, ew, ewa, ea, eda, eov, eoi);
      u_if.abort = (t == abort_at);
      u_if.start = poke && ((t == 2) || (t == tdone - 2) || (t == tdone));
      if (u_if.start) u_if.num_vec = VW'($urandom);
      tick();
    end
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
  endtask

  initial begin
    int nv, ab;
    bit pk;
    u_if.start   = 1'b0;
    u_if.abort   = 1'b0;
    u_if.num_vec = '0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    tick();

    // start and abort together in IDLE: abort wins.
    u_if.num_vec = 8'd3;
    u_if.start   = 1'b1;
    u_if.abort   = 1'b1;
    tick();
    u_if.start = 1'b0;
    u_if.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort_idle.busy", i, 32'(u_if.busy), 32'd0);
      tick();
    end

    run_job(3, 0, 0, "nominal");
    run_job(0, 0, 0, "zero_vec");
    run_job(3, 6, 0, "abort6");
    run_job(3, 0, 0, "after_abort");
    run_job(3, 0, 1, "start_poke");

    // Reset pulse mid-STREAM.
    u_if.num_vec = 8'd3;
    u_if.start   = 1'b1;
    tick();
    u_if.start = 1'b0;
    repeat (5) tick();
    chk("pre_reset.active", 6, 32'(u_if.active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("rst_async", 6, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_outs("rst_hold", 7, 0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_idle.busy", i, 32'(u_if.busy), 32'd0);
      chk("post_rst_idle.out_valid", i, 32'(u_if.out_valid), 32'd0);
    end
    run_job(3, 0, 0, "post_reset");

    // Randomized jobs, some aborted, some with start pulses while busy.
    for (int k = 0; k < 6; k++) begin
      nv = int'($urandom_range(0, 12));
      ab = 0;
      pk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        ab = int'($urandom_range(1, (nv == 0) ? N : N + nv + LAT));
        pk = 1'b0;
      end
      run_job(nv, ab, pk, "random");
    end

    run_job(255, 0, 0, "long255");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4: array dimension, i.e. the number of PE rows/columns; legal range 2..16.
REQ-002 Parameter NW, default 2: width of w_addr; 2^NW >= N.
REQ-003 Parameter VW, default 8: width of vector count and index.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 abort  input  1  synchronous job cancel.
REQ-008 num_vec  input  VW  number of activation vectors in the job; captured with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle job-complete pulse.
REQ-011 wwrite  output  1  weight shift-in enable to the PE array.
REQ-012 w_addr  output  NW  weight buffer read row.
REQ-013 active  output  1  activation streaming enable to the PE array.
REQ-014 d_addr  output  VW  activation buffer read index.
REQ-015 out_valid  output  1  a result row is present at the array bottom.
REQ-016 out_idx  output  VW  vector index of the current result row.

Function
REQ-017 The FSM SHALL have states IDLE, LOADW, STREAM, FLUSH and DONE; all outputs SHALL be registered (Moore).
REQ-018 IDLE: start=1 and abort=0 SHALL capture num_vec into nv_q and enter LOADW on the next edge.
REQ-019 LOADW SHALL last exactly N cycles with wwrite=1 and w_addr=0,1,...,N-1 (one value per cycle).
- After LOADW, the FSM SHALL enter STREAM if nv_q != 0, else DONE.
REQ-020 STREAM SHALL last exactly nv_q cycles with active=1 and d_addr=0,1,...,nv_q-1; it SHALL then enter FLUSH.
REQ-021 FLUSH SHALL last exactly LAT = 2N-1 cycles with active=0 and wwrite=0; it SHALL then enter DONE.
REQ-022 DONE SHALL last one cycle with done=1; it SHALL then enter IDLE.
REQ-023 out_valid SHALL equal active delayed by exactly LAT cycles.
- out_idx SHALL equal d_addr delayed by exactly LAT cycles.
- out_idx SHALL be 0 whenever out_valid=0.
REQ-024 The last out_valid SHALL occur in the final FLUSH cycle; no out_valid SHALL occur in DONE or IDLE.
REQ-025 Measured from the start-sampling edge, done SHALL be high in cycle N+1 when nv_q=0.
- Otherwise, done SHALL be high in cycle N+nv_q+LAT+1.
REQ-026 start while busy=1 SHALL be ignored, including in the DONE cycle; num_vec changes while busy SHALL have no effect.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
- All outputs SHALL be 0 from that edge, the out_valid/out_idx delay line SHALL be cleared, and no done pulse SHALL be generated.
REQ-028 start and abort high together in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 wwrite and active SHALL never be high in the same cycle.
REQ-030 Counters SHALL never wrap: nv_q = 2^VW-1 SHALL stream every index 0..2^VW-2 exactly once.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force IDLE, clear all counters, nv_q and the delay line, and drive every output to 0.
REQ-032 Reset asserted mid-job SHALL discard the job; after release the block SHALL accept a new start normally, with no residual out_valid.
REQ-033 rst_n deassertion SHALL be taken on a clock edge; the first start can be sampled on the edge following deassertion.

Verification
REQ-034 Nominal (N=4, num_vec=3), start one cycle:
- wwrite high cycles 1-4 with w_addr 0,1,2,3.
- active high cycles 5-7 with d_addr 0,1,2.
- out_valid high cycles 12-14 with out_idx 0,1,2.
- done cycle 15, busy low from cycle 16.
REQ-035 num_vec=0: wwrite cycles 1-4, done cycle 5, active and out_valid never high.
REQ-036 Abort injected at cycle 6 of the nominal job:
- all outputs 0 from cycle 7, no done pulse, no out_valid.
- a following start runs the full nominal sequence.
REQ-037 start pulsed during LOADW, during FLUSH and in the DONE cycle: no second job, and the sequence is identical to REQ-034.
REQ-038 rst_n pulsed low mid-STREAM:
- outputs go 0 without waiting for a clock edge.
- after release, an idle period shows busy=0 and out_valid=0.
- a fresh nominal job then matches REQ-034.
REQ-039 num_vec=255 (VW=8): exactly 255 active cycles, d_addr 0..254, 255 out_valid cycles, done at cycle 4+255+7+1=267.
